// File: rtl/soc_input_ctrl_if.sv
// Handshake bundle between the input controller and the SOC processing core.
// The master side is the controller; the slave side is the core.
interface soc_input_ctrl_if;
  logic       start_o;
  logic       done_i;
  logic [1:0] mode_o;
  logic       buzzer_en_o;
  logic       busy_o;
  logic       err_o;
  logic       abort_o;

  modport master (
    output start_o,
    output mode_o,
    output buzzer_en_o,
    output busy_o,
    output err_o,
    output abort_o,
    input  done_i
  );

  modport slave (
    input  start_o,
    input  mode_o,
    input  buzzer_en_o,
    input  busy_o,
    input  err_o,
    input  abort_o,
    output done_i
  );
endinterface

// File: rtl/soc_input_ctrl.sv
// Switch/START conditioning (2-FF sync, debounce, edge detect) and run-control FSM for the core.
// Long-press abort of a running job is built only when LONG_PRESS_ABORT_EN is defined.
module soc_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ABORT_CYCLES    = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MODE1_START_I,
  input  logic              MODE2_START_I,
  input  logic              BUZZER_MODE_I,
  input  logic              START_I,
  soc_input_ctrl_if.master  core,
  output logic              LED1_ON_o,
  output logic              LED2_ON_o,
  output logic              LED_IDLE_O
);

  localparam int unsigned NumIn    = 4;
  localparam int unsigned IdxM1    = 0;
  localparam int unsigned IdxM2    = 1;
  localparam int unsigned IdxBuz   = 2;
  localparam int unsigned IdxStart = 3;

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun1,
    StRun2,
    StErr
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [NumIn-1:0]           raw;
  logic [NumIn-1:0]           sync1_q;
  logic [NumIn-1:0]           sync2_q;
  logic [NumIn-1:0]           db_q;
  logic [NumIn-1:0]           db_d;
  logic [NumIn-1:0][CntW-1:0] cnt_q;
  logic [NumIn-1:0][CntW-1:0] cnt_d;

  assign raw = {START_I, BUZZER_MODE_I, MODE2_START_I, MODE1_START_I};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Decisions look at the debounced next values so start_o is registered on the
  // same edge that the debounced START rises; db_q is then the one-cycle delay.
  logic m1;
  logic m2;
  logic start_rise;

  assign m1         = db_d[IdxM1];
  assign m2         = db_d[IdxM2];
  assign start_rise = db_d[IdxStart] & ~db_q[IdxStart];

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  state_e     state_q;
  state_e     state_d;
  logic       start_q;
  logic       start_d;
  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic       buz_q;
  logic       buz_d;
  logic       busy_q;
  logic       busy_d;
  logic       err_q;
  logic       err_d;
  logic       led1_q;
  logic       led1_d;
  logic       led2_q;
  logic       led2_d;
  logic       idle_q;
  logic       idle_d;

`ifdef LONG_PRESS_ABORT_EN
  localparam int unsigned HoldW = (ABORT_CYCLES > 2) ? $clog2(ABORT_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(ABORT_CYCLES - 1);

  logic [HoldW-1:0] hold_q;
  logic [HoldW-1:0] hold_d;
  logic             running;
  logic             abort_hit;
  logic             abort_q;
  logic             abort_d;

  // Cleared while idle, so the press that launched a run counts from its rising edge.
  assign running   = (state_q == StRun1) || (state_q == StRun2);
  assign hold_d    = (running && db_d[IdxStart]) ? hold_q + HoldW'(1) : '0;
  assign abort_hit = running && db_d[IdxStart] && (hold_q == HoldMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      abort_q <= abort_d;
    end
  end

  assign core.abort_o = abort_q;
`else
  logic unused_abort_cfg;
  assign unused_abort_cfg = ^ABORT_CYCLES;
  assign core.abort_o     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    mode_d  = mode_q;
    buz_d   = buz_q;
`ifdef LONG_PRESS_ABORT_EN
    abort_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (start_rise) begin
          if (m1 && !m2) begin
            state_d = StRun1;
            start_d = 1'b1;
            mode_d  = 2'b01;
            buz_d   = db_d[IdxBuz];
          end else if (!m1 && m2) begin
            state_d = StRun2;
            start_d = 1'b1;
            mode_d  = 2'b10;
            buz_d   = db_d[IdxBuz];
          end else if (m1 && m2) begin
            state_d = StErr;
          end
        end
      end
      StRun1, StRun2: begin
`ifdef LONG_PRESS_ABORT_EN
        if (abort_hit) begin
          state_d = StIdle;
          abort_d = 1'b1;
          mode_d  = 2'b00;
          buz_d   = 1'b0;
        end else
`endif
        // A done coinciding with our own start pulse belongs to no job of ours.
        if (core.done_i && !start_q) begin
          state_d = StIdle;
          mode_d  = 2'b00;
          buz_d   = 1'b0;
        end
      end
      StErr: begin
        if (!m1 && !m2) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d == StRun1) || (state_d == StRun2);
  assign err_d  = (state_d == StErr);
  assign led1_d = (state_d == StRun1);
  assign led2_d = (state_d == StRun2);
  assign idle_d = (state_d == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      mode_q  <= 2'b00;
      buz_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      led1_q  <= 1'b0;
      led2_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      buz_q   <= buz_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      led1_q  <= led1_d;
      led2_q  <= led2_d;
      idle_q  <= idle_d;
    end
  end

  assign core.start_o     = start_q;
  assign core.mode_o      = mode_q;
  assign core.buzzer_en_o = buz_q;
  assign core.busy_o      = busy_q;
  assign core.err_o       = err_q;
  assign LED1_ON_o        = led1_q;
  assign LED2_ON_o        = led2_q;
  assign LED_IDLE_O       = idle_q;

endmodule

// File: tb/tb_soc_input_ctrl.sv
// Directed bench for soc_input_ctrl with DEBOUNCE_CYCLES=4, ABORT_CYCLES=20.
// Output snapshot bit order: start, mode[1:0], buzzer, busy, err, abort, led1, led2, idle.
module tb_soc_input_ctrl;

  localparam logic [9:0] OutIdle      = 10'b0_00_0_0_0_0_0_0_1;
  localparam logic [9:0] OutRun1      = 10'b0_01_0_1_0_0_1_0_0;
  localparam logic [9:0] OutRun1Start = 10'b1_01_0_1_0_0_1_0_0;
  localparam logic [9:0] OutRun2      = 10'b0_10_0_1_0_0_0_1_0;
  localparam logic [9:0] OutRun2Start = 10'b1_10_0_1_0_0_0_1_0;
  localparam logic [9:0] OutRun2Buz   = 10'b0_10_1_1_0_0_0_1_0;
  localparam logic [9:0] OutErr       = 10'b0_00_0_0_1_0_0_0_0;

  logic clk;
  logic rst;
  logic sw1;
  logic sw2;
  logic sw3;
  logic start_btn;
  logic led1;
  logic led2;
  logic led_idle;

  int vec_cnt;
  int err_cnt;

  soc_input_ctrl_if bus ();

  soc_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ABORT_CYCLES   (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MODE1_START_I(sw1),
    .MODE2_START_I(sw2),
    .BUZZER_MODE_I(sw3),
    .START_I      (start_btn),
    .core         (bus),
    .LED1_ON_o    (led1),
    .LED2_ON_o    (led2),
    .LED_IDLE_O   (led_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] snap();
    return {bus.start_o, bus.mode_o, bus.buzzer_en_o, bus.busy_o, bus.err_o, bus.abort_o,
            led1, led2, led_idle};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_done();
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b0;
    wait_n(2);
    #2;
    rst = 1'b1;
    #1;
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL reset_async: got %b expected %b", obs, OutIdle);
    end
    wait_n(2);
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL reset_held: got %b expected %b", obs, OutIdle);
    end
    rst = 1'b0;
    wait_n(2);
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL reset_release: got %b expected %b", obs, OutIdle);
    end
  endtask

  task automatic test_mode1();
    logic [9:0] obs;
    logic [9:0] exp;
    sw1 = 1'b1;
    wait_n(8);
    start_btn = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp = (n < 6) ? OutIdle : ((n == 6) ? OutRun1Start : OutRun1);
      obs = snap();
      vec_cnt++;
      if (obs !== exp) begin
        err_cnt++;
        $display("FAIL mode1_edge%0d: got %b expected %b", n, obs, exp);
      end
    end
    start_btn = 1'b0;
    wait_n(8);
    obs = snap();
    vec_cnt++;
    if (obs !== OutRun1) begin
      err_cnt++;
      $display("FAIL mode1_hold: got %b expected %b", obs, OutRun1);
    end
    pulse_done();
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL mode1_done: got %b expected %b", obs, OutIdle);
    end
    sw1 = 1'b0;
    wait_n(8);
  endtask

  task automatic test_glitch();
    logic [9:0] obs;
    logic [9:0] exp;
    sw2 = 1'b1;
    wait_n(8);
    start_btn = 1'b1;
    wait_n(3);
    start_btn = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      obs = snap();
      vec_cnt++;
      if (obs !== OutIdle) begin
        err_cnt++;
        $display("FAIL glitch_idle%0d: got %b expected %b", n, obs, OutIdle);
      end
    end
    // Real press; done_i is raised during the start_o cycle and must be ignored.
    start_btn = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      bus.done_i = 1'b0;
      exp = (n < 6) ? OutIdle : ((n == 6) ? OutRun2Start : OutRun2);
      obs = snap();
      vec_cnt++;
      if (obs !== exp) begin
        err_cnt++;
        $display("FAIL mode2_edge%0d: got %b expected %b", n, obs, exp);
      end
      if (n == 6) bus.done_i = 1'b1;
    end
    start_btn = 1'b0;
    wait_n(8);
    start_btn = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      obs = snap();
      vec_cnt++;
      if (obs !== OutRun2) begin
        err_cnt++;
        $display("FAIL mode2_repress%0d: got %b expected %b", n, obs, OutRun2);
      end
    end
    start_btn = 1'b0;
    wait_n(8);
    pulse_done();
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL mode2_done: got %b expected %b", obs, OutIdle);
    end
    sw2 = 1'b0;
    wait_n(8);
  endtask

  task automatic test_conflict();
    logic [9:0] obs;
    logic [9:0] exp;
    sw1 = 1'b1;
    sw2 = 1'b1;
    wait_n(8);
    start_btn = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp = (n < 6) ? OutIdle : OutErr;
      obs = snap();
      vec_cnt++;
      if (obs !== exp) begin
        err_cnt++;
        $display("FAIL conflict_edge%0d: got %b expected %b", n, obs, exp);
      end
    end
    start_btn = 1'b0;
    wait_n(8);
    pulse_done();
    obs = snap();
    vec_cnt++;
    if (obs !== OutErr) begin
      err_cnt++;
      $display("FAIL conflict_done_ignored: got %b expected %b", obs, OutErr);
    end
    sw2 = 1'b0;
    wait_n(8);
    obs = snap();
    vec_cnt++;
    if (obs !== OutErr) begin
      err_cnt++;
      $display("FAIL conflict_one_cleared: got %b expected %b", obs, OutErr);
    end
    sw1 = 1'b0;
    wait_n(8);
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL conflict_both_cleared: got %b expected %b", obs, OutIdle);
    end
  endtask

  task automatic test_midrun_reset();
    logic [9:0] obs;
    sw2 = 1'b1;
    sw3 = 1'b1;
    wait_n(8);
    start_btn = 1'b1;
    wait_n(8);
    obs = snap();
    vec_cnt++;
    if (obs !== OutRun2Buz) begin
      err_cnt++;
      $display("FAIL midrun_latched: got %b expected %b", obs, OutRun2Buz);
    end
    start_btn = 1'b0;
    wait_n(8);
    #2;
    rst = 1'b1;
    #1;
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL midrun_reset: got %b expected %b", obs, OutIdle);
    end
    wait_n(2);
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      obs = snap();
      vec_cnt++;
      if (obs !== OutIdle) begin
        err_cnt++;
        $display("FAIL midrun_after%0d: got %b expected %b", n, obs, OutIdle);
      end
    end
    sw2 = 1'b0;
    sw3 = 1'b0;
    wait_n(8);
  endtask

  task automatic test_long_press();
    logic [9:0] obs;
    int n_start;
    int n_abort;
    int abort_at;
    n_start  = 0;
    n_abort  = 0;
    abort_at = 0;
    sw1 = 1'b1;
    wait_n(8);
    start_btn = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.start_o === 1'b1) n_start++;
      if (bus.abort_o !== 1'b0) begin
        n_abort++;
        abort_at = n;
      end
    end
    start_btn = 1'b0;
    wait_n(10);
    obs = snap();
    vec_cnt++;
    if (n_start != 1) begin
      err_cnt++;
      $display("FAIL long_start_count: got %0d expected %0d", n_start, 1);
    end
`ifdef LONG_PRESS_ABORT_EN
    vec_cnt++;
    if (n_abort != 1) begin
      err_cnt++;
      $display("FAIL long_abort_count: got %0d expected %0d", n_abort, 1);
    end
    vec_cnt++;
    if (abort_at != 26) begin
      err_cnt++;
      $display("FAIL long_abort_edge: got %0d expected %0d", abort_at, 26);
    end
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL long_after_abort: got %b expected %b", obs, OutIdle);
    end
`else
    vec_cnt++;
    if (n_abort != 0) begin
      err_cnt++;
      $display("FAIL long_abort_count: got %0d (edge %0d) expected 0", n_abort, abort_at);
    end
    vec_cnt++;
    if (obs !== OutRun1) begin
      err_cnt++;
      $display("FAIL long_still_run1: got %b expected %b", obs, OutRun1);
    end
    pulse_done();
    obs = snap();
    vec_cnt++;
    if (obs !== OutIdle) begin
      err_cnt++;
      $display("FAIL long_done: got %b expected %b", obs, OutIdle);
    end
`endif
    sw1 = 1'b0;
    wait_n(8);
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b0;
    sw1        = 1'b0;
    sw2        = 1'b0;
    sw3        = 1'b0;
    start_btn  = 1'b0;
    bus.done_i = 1'b0;
    test_reset();
    test_mode1();
    test_glitch();
    test_conflict();
    test_midrun_reset();
    test_long_press();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/soc_input_ctrl.md
Name: soc_input_ctrl

Overview:
- Front-end control stage that sits directly upstream of the SOC processing core. It conditions the board switches and the START push-button.
- Conditioning means 2-FF synchronisation, debounce and START rising-edge detection.
- A small FSM then latches the selected mode, issues a one-cycle start pulse to the processing pipeline and drives the mode/idle LEDs.
- It holds the mode stable until the downstream core reports completion.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a synchronised input is accepted (10 ms at 50 MHz). Minimum value 2.
- ABORT_CYCLES, 100000000: START hold length that aborts a run. Used only with LONG_PRESS_ABORT_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- MODE1_START_I  in  1  raw switch SW1, selects mode 1
- MODE2_START_I  in  1  raw switch SW2, selects mode 2
- BUZZER_MODE_I  in  1  raw switch SW3, buzzer enable request
- START_I  in  1  raw START push-button
- done_i  in  1  single-cycle completion pulse from the core; synchronous, not debounced
- start_o  out  1  single-cycle start pulse to the core
- mode_o  out  2  latched mode: 00 none, 01 mode 1, 10 mode 2; 11 is never driven
- buzzer_en_o  out  1  debounced SW3, latched at start
- busy_o  out  1  high in RUN1/RUN2
- err_o  out  1  high in ERR
- abort_o  out  1  single-cycle abort pulse; tied 0 without the macro
- LED1_ON_o  out  1  high in RUN1
- LED2_ON_o  out  1  high in RUN2
- LED_IDLE_O  out  1  high in IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - All synchronisers, debounced values, counters and output registers clear to 0.
  - FSM goes to IDLE.
  - Reset values: LED_IDLE_O=1; every other output 0.
  - Reset mid-run aborts immediately; no start_o or abort_o is emitted.
- Synchroniser: each of the four raw inputs passes through 2 flops (q1, q2).
- Debounce (per input, counter width $clog2(DEBOUNCE_CYCLES)):
  - If q2 == db, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, db <= q2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- Edge detect: start_rise = db_start & ~db_start_d, where db_start_d is db_start delayed by 1 cycle.
- Latency: start_o rises on the (DEBOUNCE_CYCLES+2)th clk edge after the edge that first samples START_I=1, then falls after exactly 1 cycle.
- All outputs are registered.
- FSM states: IDLE, RUN1, RUN2, ERR.
- IDLE, on start_rise:
  - db_m1=1, db_m2=0 -> RUN1. Assert start_o for 1 cycle, mode_o=01, latch buzzer_en_o.
  - db_m1=0, db_m2=1 -> RUN2. Same as above but mode_o=10.
  - Both switches set -> ERR.
  - Neither switch set -> stay in IDLE, no output change.
- RUN1/RUN2:
  - Switch changes and further START presses are ignored.
  - mode_o and buzzer_en_o hold their latched values.
  - On done_i=1 -> IDLE; mode_o <= 00, buzzer_en_o <= 0.
  - done_i arriving in the same cycle as start_o is ignored.
- ERR: stays until db_m1=0 and db_m2=0, then -> IDLE. START is ignored in ERR.
- done_i received in IDLE or ERR is ignored.
- A press held through completion does not restart the core; a new rising edge is required.

Optional Feature:
- Macro: LONG_PRESS_ABORT_EN.
- Defined:
  - A hold counter runs while db_start=1 in RUN1/RUN2 and clears whenever db_start=0.
  - When it reaches ABORT_CYCLES-1, abort_o pulses for 1 cycle and the FSM goes to IDLE with mode_o=00.
  - The press that started the run counts from its own rising edge.
  - If done_i coincides with the abort cycle, abort wins (abort_o=1).
- Undefined: the counter is not synthesised and abort_o is constant 0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and ABORT_CYCLES=20.
- Reset state: assert rst mid-cycle -> all outputs 0 and LED_IDLE_O=1 immediately (asynchronous), with no clock edge needed.
- Mode 1 start: SW1=1, then START high for 10 cycles -> start_o high exactly on the 6th edge after sampling, for 1 cycle; mode_o=01; LED1_ON_o=1; busy_o=1. A done_i pulse then gives mode_o=00 and LED_IDLE_O=1.
- Glitch rejection: START high for 3 cycles -> no start_o and state stays IDLE. A second press during RUN2 -> no second start_o.
- Conflicting modes: SW1=SW2=1, then press START -> err_o=1 and no start_o. Clear SW2 only -> stays in ERR. Clear both -> IDLE.
- Mid-run reset: in RUN2 with buzzer latched (SW3=1), pulse rst for 2 cycles -> mode_o=00 and buzzer_en_o=0. After rst is released, no start_o is emitted unless there is a new press.
- LONG_PRESS_ABORT_EN defined: hold START for 30 cycles in SW1 mode -> start_o, then a single-cycle abort_o, then IDLE. With the macro undefined, the same stimulus gives abort_o=0 and the state stays RUN1.
